alu_serial_rx: RTL and testbench
================================

ALU_SERIAL_RX -- requirements
Module: alu_serial_rx

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, giving the operand width in bits; legal values are 8, 16, 24, 32, 40, 48, 56, 64.
REQ-002 The block SHALL derive localparam BYTES = DATA_W/8 and SHALL fail elaboration when DATA_W is not a legal value.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset; ports below.
REQ-004 clk  input  1  posedge-active clock.
REQ-005 rst  input  1  synchronous reset, active high.
REQ-006 sin  input  1  serial data in; idle level 1; one bit per clk.
REQ-007 a_out  output  DATA_W  operand A of the last good packet.
REQ-008 b_out  output  DATA_W  operand B of the last good packet.
REQ-009 op_out  output  3  opcode of the last good packet.
REQ-010 valid  output  1  one-cycle pulse: a_out/b_out/op_out updated.
REQ-011 err_valid  output  1  one-cycle pulse: packet rejected.
REQ-012 err_flags  output  3  {err_data, err_crc, err_op}; only meaningful while err_valid=1.

Function
REQ-013 Frame format SHALL be 11 bits, one bit per clock, in this order: start=0, ctl, data[7] ... data[0] (MSB first), stop=1.
REQ-014 The FSM SHALL have states IDLE (sample sin each edge, leave on sin=0) and BITS (sample the 10 remaining bits with a 4-bit counter, then return to IDLE).
REQ-015 A new start bit SHALL be accepted on the edge immediately after a stop bit, so back-to-back frames need zero idle cycles.
REQ-016 ctl=0 SHALL mark a data frame and ctl=1 a command frame.
REQ-017 A packet SHALL be 2*BYTES data frames followed by one command frame.
REQ-018 The first BYTES data frames SHALL form B, most significant byte first; the next BYTES SHALL form A, also MSB first.
REQ-019 The command byte SHALL be {x, OP[2:0], CRC[3:0]}; bit 7 is ignored.
REQ-020 CRC SHALL be CRC-4, polynomial x^4+x+1, initial value 0000, computed over the (2*DATA_W+4)-bit string {B, A, 1'b1, OP} MSB first; the implementation may compute it serially or in parallel.
REQ-021 Legal OP values SHALL be 000 (AND), 001 (OR), 100 (ADD) and 101 (SUB); all others are illegal.
REQ-022 A command frame arriving after fewer than 2*BYTES data frames SHALL raise err_data.
REQ-023 A data frame arriving when 2*BYTES data frames are already held SHALL raise err_data at the end of that frame.
REQ-024 A stop bit sampled as 0 SHALL raise err_data at the end of that frame.
REQ-025 If the data-frame count is correct and the CRC mismatches, the block SHALL raise err_crc.
REQ-026 If the count and CRC are correct and OP is illegal, the block SHALL raise err_op.
REQ-027 Flag priority SHALL be err_data > err_crc > err_op; err_flags SHALL be one-hot, holding only the winning flag.
REQ-028 On a good packet, valid=1 SHALL be asserted for exactly one cycle, starting at the edge after the edge that samples the command frame's stop bit; a_out, b_out and op_out SHALL update on that same edge.
REQ-029 err_valid SHALL use the same one-cycle latency and pulse width as valid.
REQ-030 valid and err_valid SHALL never be high in the same cycle.
REQ-031 Any error SHALL discard the partial packet and clear the data-frame count, so the next frame starts a new packet.
REQ-032 a_out, b_out and op_out SHALL hold their values until the next valid and SHALL NOT change on error.
REQ-033 The data-frame count SHALL be wide enough for 2*BYTES+1 (max 17) without wrap-around.

Reset
REQ-034 While rst=1 the block SHALL force: FSM=IDLE, bit counter=0, frame count=0, CRC=0000, a_out=0, b_out=0, op_out=000, valid=0, err_valid=0, err_flags=000.
REQ-035 Reset asserted mid-frame or mid-packet SHALL discard all partial data and SHALL produce no valid or err_valid pulse.
REQ-036 After rst falls, the first start bit SHALL be accepted on the first edge at which sin=0.

Verification
REQ-037 DATA_W=32; B=20, A=19, OP=100, correct CRC -> one valid pulse 1 cycle after the cmd stop bit, with b_out=20, a_out=19, op_out=100; err_valid stays 0.
REQ-038 DATA_W=32; same packet with CRC bits inverted -> err_valid pulse with err_flags=010; a_out/b_out/op_out unchanged.
REQ-039 DATA_W=32; OP=010 with correct CRC -> err_flags=001; then 7 data frames + cmd -> err_flags=100; then 9 data frames -> err_flags=100 at the 9th frame.
REQ-040 DATA_W=16; B=16'hFFFF, A=16'h0000, OP=101, correct CRC (4 data frames + cmd) -> valid, b_out=FFFF, a_out=0000.
REQ-041 DATA_W=32; two good packets with zero idle cycles between frames -> exactly two valid pulses carrying the correct second operands; data frame with stop=0 -> err_flags=100.
REQ-042 DATA_W=32; rst pulsed for 1 cycle during frame 5, then a full good packet -> no pulse for the aborted packet and exactly one valid for the new one.

Source files
------------

// File: rtl/alu_serial_rx_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_serial_rx_if
// Purpose  : Bundle of the serial input and the decoded packet result for the
//            serial ALU-command receiver.
// Revision : 1.0  initial release
// ============================================================================
interface alu_serial_rx_if #(
  parameter int DATA_W = 32
);
  logic              sin;
  logic [DATA_W-1:0] a_out;
  logic [DATA_W-1:0] b_out;
  logic [2:0]        op_out;
  logic              valid;
  logic              err_valid;
  logic [2:0]        err_flags;

  // Receiver side: consumes the serial line, produces the decoded results
  modport master (
    input  sin,
    output a_out, b_out, op_out, valid, err_valid, err_flags
  );

  // Host side: drives the serial line, consumes the decoded results
  modport slave (
    output sin,
    input  a_out, b_out, op_out, valid, err_valid, err_flags
  );
endinterface
`default_nettype wire

// File: rtl/alu_serial_rx.sv
`default_nettype none
// ============================================================================
// Module   : alu_serial_rx
// Purpose  : Receives 11-bit serial frames (start, ctl, 8 data MSB first, stop),
//            assembles 2*BYTES data frames plus one command frame into
//            operands B, A and an opcode, checks CRC-4 and opcode legality.
// Revision : 1.0  initial release
// ============================================================================
module alu_serial_rx #(
  parameter int DATA_W = 32
) (
  input  logic            clk,
  input  logic            rst,
  alu_serial_rx_if.master bus
);

  localparam int         BYTES  = DATA_W / 8;
  localparam logic [4:0] NFRM_C = 5'(2 * BYTES);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BITS = 1'b1;

  generate
    if ((DATA_W % 8 != 0) || (DATA_W < 8) || (DATA_W > 64)) begin : g_bad_width
      $error("alu_serial_rx: DATA_W must be a multiple of 8 between 8 and 64");
    end
  endgenerate

  // One serial CRC-4 step, polynomial x^4 + x + 1, MSB first
  function automatic logic [3:0] crc_step(input logic [3:0] c, input logic b);
    logic fb;
    fb = c[3] ^ b;
    return {c[2:0], 1'b0} ^ {2'b00, fb, fb};
  endfunction

  logic [0:0]          state;
  logic [0:0]          state_nxt;
  logic [3:0]          bit_cnt;
  logic [8:0]          shreg;
  logic                sample_bit;
  logic                frame_end;

  logic                fr_done;
  logic                fr_ctl;
  logic                fr_stop;
  logic [7:0]          fr_data;

  logic [4:0]          frm_cnt;
  logic [3:0]          crc;
  logic [2*DATA_W-1:0] opnd;

  logic [3:0]          crc_data_nxt;
  logic [3:0]          crc_cmd;
  logic [2:0]          cmd_op;
  logic [3:0]          cmd_crc;
  logic                cnt_full;
  logic                op_legal;
  logic                accept_data;
  logic                err_data;
  logic                err_crc;
  logic                err_op;
  logic                good;

  logic [DATA_W-1:0]   a_r;
  logic [DATA_W-1:0]   b_r;
  logic [2:0]          op_r;
  logic                valid_r;
  logic                err_valid_r;
  logic [2:0]          err_flags_r;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // FSM next state: leave IDLE on a start bit, return after the stop bit
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (!bus.sin) state_nxt = S_BITS;
      S_BITS:  if (bit_cnt == 4'd9) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs: bits 0..8 of BITS are ctl+data, bit 9 is the stop bit
  always_comb begin
    sample_bit = 1'b0;
    frame_end  = 1'b0;
    if (state == S_BITS) begin
      if (bit_cnt == 4'd9) frame_end  = 1'b1;
      else                 sample_bit = 1'b1;
    end
  end

  // Bit counter and ctl/data shift register
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt <= 4'd0;
      shreg   <= 9'd0;
    end else if (state == S_IDLE) begin
      bit_cnt <= 4'd0;
    end else begin
      bit_cnt <= frame_end ? 4'd0 : bit_cnt + 4'd1;
      if (sample_bit) shreg <= {shreg[7:0], bus.sin};
    end
  end

  // Capture a completed frame; it is judged on the following edge
  always_ff @(posedge clk) begin
    if (rst) begin
      fr_done <= 1'b0;
      fr_ctl  <= 1'b0;
      fr_stop <= 1'b0;
      fr_data <= 8'd0;
    end else begin
      fr_done <= frame_end;
      if (frame_end) begin
        fr_ctl  <= shreg[8];
        fr_data <= shreg[7:0];
        fr_stop <= bus.sin;
      end
    end
  end

  assign cmd_op   = fr_data[6:4];
  assign cmd_crc  = fr_data[3:0];
  assign cnt_full = (frm_cnt == NFRM_C);
  assign op_legal = (cmd_op == 3'b000) || (cmd_op == 3'b001) ||
                    (cmd_op == 3'b100) || (cmd_op == 3'b101);

  // Frame verdict: CRC folds and the mutually exclusive error/good decision
  always_comb begin
    crc_data_nxt = crc;
    for (int i = 7; i >= 0; i--) crc_data_nxt = crc_step(crc_data_nxt, fr_data[i]);
    crc_cmd = crc_step(crc, 1'b1);
    for (int i = 2; i >= 0; i--) crc_cmd = crc_step(crc_cmd, cmd_op[i]);

    accept_data = fr_done && fr_stop && !fr_ctl && !cnt_full;
    err_data    = fr_done && (!fr_stop || (fr_ctl != cnt_full));
    err_crc     = fr_done && fr_stop && fr_ctl && cnt_full && (crc_cmd != cmd_crc);
    err_op      = fr_done && fr_stop && fr_ctl && cnt_full && (crc_cmd == cmd_crc) && !op_legal;
    good        = fr_done && fr_stop && fr_ctl && cnt_full && (crc_cmd == cmd_crc) && op_legal;
  end

  // Packet accumulator: frame count, running CRC and {B, A} shift register
  always_ff @(posedge clk) begin
    if (rst) begin
      frm_cnt <= 5'd0;
      crc     <= 4'd0;
      opnd    <= '0;
    end else if (fr_done) begin
      if (accept_data) begin
        frm_cnt <= frm_cnt + 5'd1;
        crc     <= crc_data_nxt;
        opnd    <= {opnd[2*DATA_W-9:0], fr_data};
      end else begin
        // Command frame or error: packet ends, next frame starts afresh
        frm_cnt <= 5'd0;
        crc     <= 4'd0;
      end
    end
  end

  // Result registers and one-cycle result/error pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r         <= '0;
      b_r         <= '0;
      op_r        <= 3'd0;
      valid_r     <= 1'b0;
      err_valid_r <= 1'b0;
      err_flags_r <= 3'd0;
    end else begin
      valid_r     <= good;
      err_valid_r <= err_data || err_crc || err_op;
      err_flags_r <= err_data ? 3'b100 : err_crc ? 3'b010 : err_op ? 3'b001 : 3'b000;
      if (good) begin
        b_r  <= opnd[2*DATA_W-1:DATA_W];
        a_r  <= opnd[DATA_W-1:0];
        op_r <= cmd_op;
      end
    end
  end

  assign bus.a_out     = a_r;
  assign bus.b_out     = b_r;
  assign bus.op_out    = op_r;
  assign bus.valid     = valid_r;
  assign bus.err_valid = err_valid_r;
  assign bus.err_flags = err_flags_r;

endmodule
`default_nettype wire

// File: tb/tb_alu_serial_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_serial_rx
// Purpose  : Directed self-checking bench for alu_serial_rx at DATA_W=32 and
//            DATA_W=16 against a packet-level reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_alu_serial_rx;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_serial_rx_if #(.DATA_W(32)) bus32 ();
  alu_serial_rx_if #(.DATA_W(16)) bus16 ();

  alu_serial_rx #(.DATA_W(32)) dut32 (.clk(clk), .rst(rst), .bus(bus32.master));
  alu_serial_rx #(.DATA_W(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16.master));

  logic        sin_v [2];
  assign bus32.sin = sin_v[0];
  assign bus16.sin = sin_v[1];

  logic [63:0] a_act [2];
  logic [63:0] b_act [2];
  logic [2:0]  op_act[2];
  logic [2:0]  fl_act[2];
  logic        v_act [2];
  logic        e_act [2];
  assign a_act[0] = 64'(bus32.a_out);   assign a_act[1] = 64'(bus16.a_out);
  assign b_act[0] = 64'(bus32.b_out);   assign b_act[1] = 64'(bus16.b_out);
  assign op_act[0] = bus32.op_out;      assign op_act[1] = bus16.op_out;
  assign fl_act[0] = bus32.err_flags;   assign fl_act[1] = bus16.err_flags;
  assign v_act[0]  = bus32.valid;       assign v_act[1]  = bus16.valid;
  assign e_act[0]  = bus32.err_valid;   assign e_act[1]  = bus16.err_valid;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model state
  logic [7:0]  held  [2][16];
  int          nheld [2];
  longint      ev_cyc[2];
  logic        ev_v  [2];
  logic        ev_e  [2];
  logic [2:0]  ev_fl [2];
  logic [2:0]  ev_op [2];
  logic [63:0] ev_a  [2];
  logic [63:0] ev_b  [2];
  logic [63:0] cur_a [2];
  logic [63:0] cur_b [2];
  logic [2:0]  cur_op[2];
  int          nvalid[2];
  int          nerr  [2];

  int checks = 0;
  int errors = 0;

  function automatic int width_of(input int d);
    return (d == 0) ? 32 : 16;
  endfunction

  // CRC-4 (x^4+x+1, init 0) of the n-bit string s by long division of s*x^4
  function automatic logic [3:0] crc4(input logic [131:0] s, input int n);
    logic [135:0] m;
    m = {s, 4'b0000};
    for (int i = n + 3; i >= 4; i--)
      if (m[i]) m[i -: 5] = m[i -: 5] ^ 5'b10011;
    return m[3:0];
  endfunction

  function automatic logic [131:0] pkt_string(input logic [63:0] b, input logic [63:0] a,
                                              input logic [2:0] op, input int w);
    return (132'(b) << (w + 4)) | (132'(a) << 4) | 132'(8) | 132'(op);
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Packet-level model: judge a complete frame and schedule the resulting pulse
  task automatic model_frame(input int d, input logic ctl, input logic [7:0] data, input logic stop);
    int          nb;
    int          w;
    logic [2:0]  fl;
    logic [63:0] b;
    logic [63:0] a;
    logic [2:0]  op;
    w  = width_of(d);
    nb = 2 * (w / 8);
    fl = 3'b000;
    b  = '0;
    a  = '0;
    op = data[6:4];
    if (!stop) fl = 3'b100;
    else if (!ctl) begin
      if (nheld[d] == nb) fl = 3'b100;
      else begin
        held[d][nheld[d]] = data;
        nheld[d]++;
        return;
      end
    end else if (nheld[d] != nb) fl = 3'b100;
    else begin
      for (int i = 0; i < nb / 2; i++)  b = (b << 8) | 64'(held[d][i]);
      for (int i = nb / 2; i < nb; i++) a = (a << 8) | 64'(held[d][i]);
      if (crc4(pkt_string(b, a, op, w), 2 * w + 4) != data[3:0]) fl = 3'b010;
      else if (!(op == 3'b000 || op == 3'b001 || op == 3'b100 || op == 3'b101)) fl = 3'b001;
    end
    nheld[d]  = 0;
    ev_cyc[d] = cyc + 1;
    ev_v[d]   = (fl == 3'b000);
    ev_e[d]   = (fl != 3'b000);
    ev_fl[d]  = fl;
    ev_a[d]   = a;
    ev_b[d]   = b;
    ev_op[d]  = op;
  endtask

  task automatic send_bit(input int d, input logic b);
    sin_v[d] = b;
    @(negedge clk);
  endtask

  task automatic send_frame(input int d, input logic ctl, input logic [7:0] data, input logic stop);
    send_bit(d, 1'b0);
    send_bit(d, ctl);
    for (int i = 7; i >= 0; i--) send_bit(d, data[i]);
    send_bit(d, stop);
    sin_v[d] = 1'b1;
    model_frame(d, ctl, data, stop);
  endtask

  task automatic idle(input int d, input int n);
    sin_v[d] = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_data(input int d, input logic [63:0] v, input int nbytes);
    for (int i = nbytes - 1; i >= 0; i--) send_frame(d, 1'b0, 8'(v >> (8 * i)), 1'b1);
  endtask

  task automatic send_packet(input int d, input logic [63:0] b, input logic [63:0] a,
                             input logic [2:0] op, input logic [3:0] crc_xor, input int gap);
    int         w;
    logic [3:0] c;
    w = width_of(d);
    send_data(d, b, w / 8);
    send_data(d, a, w / 8);
    c = crc4(pkt_string(b, a, op, w), 2 * w + 4) ^ crc_xor;
    send_frame(d, 1'b1, {1'b0, op, c}, 1'b1);
    idle(d, gap);
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    sin_v[0] = 1'b1;
    sin_v[1] = 1'b1;
    for (int d = 0; d < 2; d++) begin
      nheld[d]  = 0;
      ev_cyc[d] = -1;
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    sin_v[0] = 1'b1;
    sin_v[1] = 1'b1;
    for (int d = 0; d < 2; d++) begin
      nheld[d] = 0;  ev_cyc[d] = -1; ev_v[d] = 0; ev_e[d] = 0; ev_fl[d] = 0;
      ev_op[d] = 0;  ev_a[d] = 0;    ev_b[d] = 0; cur_a[d] = 0; cur_b[d] = 0;
      cur_op[d] = 0; nvalid[d] = 0;  nerr[d] = 0;
    end

    fork
      begin : stimulus
        // CRC model pinned against hand-computed remainders
        check("crc4 of 1000", 64'(crc4(132'h8, 4)), 64'hB);
        check("crc4 of 0x80", 64'(crc4(132'h80, 8)), 64'hE);

        do_reset();
        check("reset valid", 64'(v_act[0]), 64'd0);
        check("reset err_valid", 64'(e_act[0]), 64'd0);
        check("reset a_out", a_act[0], 64'd0);
        check("reset err_flags", 64'(fl_act[0]), 64'd0);

        // Good packet B=20 A=19 ADD
        send_packet(0, 64'd20, 64'd19, 3'b100, 4'h0, 3);
        check("pkt1 b_out", b_act[0], 64'd20);
        check("pkt1 a_out", a_act[0], 64'd19);
        check("pkt1 op_out", 64'(op_act[0]), 64'd4);

        // Same packet with CRC inverted -> err_crc, outputs held
        send_packet(0, 64'd20, 64'd19, 3'b100, 4'hF, 3);
        check("crcerr a_out held", a_act[0], 64'd19);

        // Illegal opcode with correct CRC -> err_op
        send_packet(0, 64'd5, 64'd6, 3'b010, 4'h0, 2);

        // Seven data frames then command -> err_data
        send_data(0, 64'h01020304, 4);
        send_data(0, 64'h050607, 3);
        send_frame(0, 1'b1, 8'h40, 1'b1);
        idle(0, 2);

        // Nine data frames -> err_data on the ninth
        send_data(0, 64'h1112131415161718, 8);
        send_frame(0, 1'b0, 8'h19, 1'b1);
        idle(0, 2);

        // Two back-to-back good packets, zero idle cycles
        send_packet(0, 64'h12345678, 64'h9ABCDEF0, 3'b000, 4'h0, 0);
        send_packet(0, 64'hDEADBEEF, 64'h0BADF00D, 3'b101, 4'h0, 2);
        check("b2b b_out", b_act[0], 64'hDEADBEEF);
        check("b2b a_out", a_act[0], 64'h0BADF00D);

        // Data frame with stop=0 -> err_data
        send_frame(0, 1'b0, 8'hA5, 1'b0);
        idle(0, 2);

        // Reset during frame 5 of a packet, then a fresh good packet
        send_data(0, 64'hCAFEBABE, 4);
        send_bit(0, 1'b0);
        send_bit(0, 1'b0);
        send_bit(0, 1'b1);
        send_bit(0, 1'b0);
        do_reset();
        send_packet(0, 64'd7, 64'd3, 3'b001, 4'h0, 3);
        check("post-reset b_out", b_act[0], 64'd7);

        // 16-bit instance: B=FFFF A=0000 SUB
        send_packet(1, 64'hFFFF, 64'h0000, 3'b101, 4'h0, 3);
        check("w16 b_out", b_act[1], 64'hFFFF);
        check("w16 a_out", a_act[1], 64'h0000);
        check("w16 op_out", 64'(op_act[1]), 64'd5);

        idle(0, 2);
        check("dut32 valid pulses", 64'(nvalid[0]), 64'd4);
        check("dut32 error pulses", 64'(nerr[0]), 64'd5);
        check("dut16 valid pulses", 64'(nvalid[1]), 64'd1);
        check("dut16 error pulses", 64'(nerr[1]), 64'd0);
      end
      begin : compare
        forever begin
          @(negedge clk);
          for (int d = 0; d < 2; d++) begin
            logic exp_v;
            logic exp_e;
            if (rst) begin
              cur_a[d]  = '0;
              cur_b[d]  = '0;
              cur_op[d] = '0;
            end else begin
              exp_v = 1'b0;
              exp_e = 1'b0;
              if (cyc == ev_cyc[d]) begin
                exp_v = ev_v[d];
                exp_e = ev_e[d];
                if (ev_v[d]) begin
                  cur_a[d]  = ev_a[d];
                  cur_b[d]  = ev_b[d];
                  cur_op[d] = ev_op[d];
                end
              end
              if (v_act[d]) nvalid[d]++;
              if (e_act[d]) nerr[d]++;
              check($sformatf("dut%0d valid", d), 64'(v_act[d]), 64'(exp_v));
              check($sformatf("dut%0d err_valid", d), 64'(e_act[d]), 64'(exp_e));
              if (exp_e) check($sformatf("dut%0d err_flags", d), 64'(fl_act[d]), 64'(ev_fl[d]));
              check($sformatf("dut%0d a_out", d), a_act[d], cur_a[d]);
              check($sformatf("dut%0d b_out", d), b_act[d], cur_b[d]);
              check($sformatf("dut%0d op_out", d), 64'(op_act[d]), 64'(cur_op[d]));
            end
          end
        end
      end
    join_any
    disable fork;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
